// File: rtl/eq_pkg.sv
// Shared types for the receive symbol scheduler: subcarrier index codes,
// scheduler FSM states and a pilot-count helper.
package eq_pkg;

    // Subcarrier classification handed to the equalizer.
    typedef enum logic [1:0] {
        IDX_NULL  = 2'd0,
        IDX_DATA  = 2'd1,
        IDX_PILOT = 2'd2,
        IDX_RSVD  = 2'd3
    } idx_e;

    // Scheduler states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_OVERRUN = 2'd2
    } state_e;

    // Number of pilots carried in one symbol.
    function automatic int n_pilot(input int n_act, input int step);
        return n_act / step;
    endfunction

endpackage

// File: rtl/eq_bin_map.sv
// Combinational bin classifier. Given the bin number and the current phase
// inside the pilot grid, returns the subcarrier index, a pilot strobe and the
// next grid phase. The phase only advances inside the active band, so it is 0
// on the first active bin and reaches step_pilot-1 on every pilot.
module eq_bin_map
    import eq_pkg::*;
#(
    parameter int first_bin  = 28,
    parameter int n_active   = 200,
    parameter int step_pilot = 4,
    parameter int bin_w      = 9,
    parameter int mod_w      = 2
) (
    input  logic [bin_w-1:0] bin_i,
    input  logic [mod_w-1:0] mod_i,
    output logic [1:0]       idx_o,
    output logic             pilot_o,
    output logic [mod_w-1:0] mod_next_o
);

    localparam logic [bin_w-1:0] ACT_LO   = bin_w'(first_bin);
    localparam logic [bin_w-1:0] ACT_HI   = bin_w'(first_bin + n_active);
    localparam logic [mod_w-1:0] MOD_LAST = mod_w'(step_pilot - 1);

    // Classify the bin and advance the pilot-grid phase.
    always_comb begin
        idx_o      = IDX_NULL;
        pilot_o    = 1'b0;
        mod_next_o = mod_i;
        if ((bin_i >= ACT_LO) && (bin_i < ACT_HI)) begin
            if (mod_i == MOD_LAST) begin
                idx_o      = IDX_PILOT;
                pilot_o    = 1'b1;
                mod_next_o = mod_w'(0);
            end else begin
                idx_o      = IDX_DATA;
                pilot_o    = 1'b0;
                mod_next_o = mod_i + mod_w'(1);
            end
        end else begin
            idx_o      = IDX_NULL;
            pilot_o    = 1'b0;
            mod_next_o = mod_i;
        end
    end

endmodule

// File: rtl/eq_sym_sched.sv
// Symbol scheduler between the FFT output and the subcarrier equalizer.
// Counts bins per OFDM symbol, tags each bin null/data/pilot, reports short
// and long symbols, and only honours enable changes at symbol boundaries.
// Every output is registered one clock after its input bin.
module eq_sym_sched
    import eq_pkg::*;
#(
    parameter int fft_depth  = 12,
    parameter int fft_size   = 256,
    parameter int first_bin  = 28,
    parameter int n_active   = 200,
    parameter int step_pilot = 4,
    parameter int sym_w      = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  ival,
    input  logic                                  isop,
    input  logic signed [fft_depth-1:0]           isub_i,
    input  logic signed [fft_depth-1:0]           isub_q,
    output logic                                  oval,
    output logic                                  osop,
    output logic [1:0]                            oindex,
    output logic signed [fft_depth-1:0]           osub_i,
    output logic signed [fft_depth-1:0]           osub_q,
    output logic [$clog2(n_active/step_pilot)-1:0] opilot_idx,
    output logic [sym_w-1:0]                      osym_cnt,
    output logic                                  err_short,
    output logic                                  err_long,
    output logic                                  busy
);

    // Bin counter holds fft_size as a "symbol just finished" marker, hence +1.
    localparam int BW = $clog2(fft_size + 1);
    localparam int MW = (step_pilot > 1) ? $clog2(step_pilot) : 1;
    localparam int PW = $clog2(n_pilot(n_active, step_pilot));
    localparam logic [BW-1:0] LAST_BIN = BW'(fft_size - 1);
    localparam logic [BW-1:0] END_BIN  = BW'(fft_size);

    state_e          state_q, state_d, ctl_state_s;
    logic [BW-1:0]   bin_q, bin_d, cur_bin_s;
    logic [MW-1:0]   mod_q, mod_d, cur_mod_s, map_mod_next_s;
    logic [PW-1:0]   pil_q, pil_d, cur_pil_s;
    logic [sym_w-1:0] sym_q, sym_d;
    logic            start_s, accept_s, err_short_s, err_long_s;
    logic [1:0]      map_idx_s;
    logic            map_pilot_s;

    // Decide what the incoming sample does: start, continue, flag or drop.
    always_comb begin
        ctl_state_s = state_q;
        start_s     = 1'b0;
        accept_s    = 1'b0;
        err_short_s = 1'b0;
        err_long_s  = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVERRUN: begin
                if (ival && isop && en) begin
                    start_s     = 1'b1;
                    accept_s    = 1'b1;
                    ctl_state_s = ST_RUN;
                end else begin
                    ctl_state_s = state_q;
                end
            end
            ST_RUN: begin
                if (!ival) begin
                    ctl_state_s = ST_RUN;
                end else if (bin_q == END_BIN) begin
                    // Previous symbol complete; only a new isop is legal here.
                    if (isop && en) begin
                        start_s  = 1'b1;
                        accept_s = 1'b1;
                    end else if (isop) begin
                        ctl_state_s = ST_IDLE;
                    end else begin
                        ctl_state_s = ST_OVERRUN;
                        err_long_s  = 1'b1;
                    end
                end else if (isop) begin
                    // Early isop: abandon the current symbol.
                    err_short_s = 1'b1;
                    if (en) begin
                        start_s  = 1'b1;
                        accept_s = 1'b1;
                    end else begin
                        ctl_state_s = ST_IDLE;
                    end
                end else begin
                    accept_s = 1'b1;
                end
            end
            default: begin
                ctl_state_s = ST_IDLE;
            end
        endcase
    end

    // A starting sample is bin 0 with all per-symbol counters cleared.
    assign cur_bin_s = start_s ? BW'(0) : bin_q;
    assign cur_mod_s = start_s ? MW'(0) : mod_q;
    assign cur_pil_s = start_s ? PW'(0) : pil_q;

    eq_bin_map #(
        .first_bin  (first_bin),
        .n_active   (n_active),
        .step_pilot (step_pilot),
        .bin_w      (BW),
        .mod_w      (MW)
    ) u_bin_map (
        .bin_i      (cur_bin_s),
        .mod_i      (cur_mod_s),
        .idx_o      (map_idx_s),
        .pilot_o    (map_pilot_s),
        .mod_next_o (map_mod_next_s)
    );

    // Advance counters for an accepted bin and resolve the end-of-symbol state.
    always_comb begin
        state_d = ctl_state_s;
        bin_d   = bin_q;
        mod_d   = mod_q;
        pil_d   = pil_q;
        sym_d   = sym_q;
        if (accept_s) begin
            bin_d = cur_bin_s + BW'(1);
            mod_d = map_mod_next_s;
            pil_d = cur_pil_s + PW'(map_pilot_s);
            if (cur_bin_s == LAST_BIN) begin
                sym_d = sym_q + sym_w'(1);
                if (en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            state_d = ctl_state_s;
        end
    end

    // FSM state and per-symbol counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            bin_q   <= BW'(0);
            mod_q   <= MW'(0);
            pil_q   <= PW'(0);
            sym_q   <= sym_w'(0);
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            mod_q   <= mod_d;
            pil_q   <= pil_d;
            sym_q   <= sym_d;
        end
    end

    // Output register stage, one clock behind the input bin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oval       <= 1'b0;
            osop       <= 1'b0;
            oindex     <= 2'd0;
            osub_i     <= fft_depth'(0);
            osub_q     <= fft_depth'(0);
            opilot_idx <= PW'(0);
            osym_cnt   <= sym_w'(0);
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            oval       <= accept_s;
            osop       <= accept_s && start_s;
            oindex     <= accept_s ? map_idx_s : 2'd0;
            osub_i     <= accept_s ? isub_i : fft_depth'(0);
            osub_q     <= accept_s ? isub_q : fft_depth'(0);
            opilot_idx <= (accept_s && map_pilot_s) ? cur_pil_s : PW'(0);
            osym_cnt   <= sym_q;
            err_short  <= err_short_s;
            err_long   <= err_long_s;
            busy       <= (state_d == ST_RUN);
        end
    end

endmodule

// File: doc/eq_sym_sched.md
# eq_sym_sched

Symbol scheduler for the receive subcarrier equalizer. It sits between the FFT output stream and the sub-carrier equalizer. It counts FFT bins per OFDM symbol and tags each bin with a 2-bit subcarrier index (null / data / pilot) that the equalizer uses to pick pilots and data. It also reports symbol framing errors and supports a clean enable/disable at symbol boundaries.

## Interface
Parameters:
- fft_depth, 12: I/Q sample width.
- fft_size, 256: bins per symbol.
- first_bin, 28: first active bin.
- n_active, 200: active bins; must be a multiple of step_pilot and satisfy first_bin + n_active <= fft_size.
- step_pilot, 4: pilot spacing inside the active band.
- sym_w, 16: symbol counter width.

Ports:
- clk, in, 1: clock. One clock domain.
- rst, in, 1: reset, asynchronous, active-low.
- en, in, 1: scheduler enable. Sampled only at symbol boundaries.
- ival, in, 1: input sample valid.
- isop, in, 1: first bin of a symbol. Qualified by ival.
- isub_i, in, fft_depth: signed I sample.
- isub_q, in, fft_depth: signed Q sample.
- oval, out, 1: output valid.
- osop, out, 1: output start of symbol.
- oindex, out, 2: subcarrier index. 0 = null, 1 = data, 2 = pilot; 3 is never driven.
- osub_i, out, fft_depth: I sample, registered.
- osub_q, out, fft_depth: Q sample, registered.
- opilot_idx, out, $clog2(n_active/step_pilot): pilot ordinal within the symbol.
- osym_cnt, out, sym_w: number of completed symbols.
- err_short, out, 1: one-cycle pulse; symbol aborted by an early isop.
- err_long, out, 1: one-cycle pulse; bins beyond fft_size.
- busy, out, 1: a symbol is in progress.

## Operation
- FSM states are IDLE, RUN and OVERRUN.
- IDLE: an ival&isop with en=1 enters RUN with bin=0. Samples without isop are dropped (oval=0). If en=0, isop is ignored.
- RUN: bin increments on each ival. ival=0 cycles freeze every counter and drive oval=0.
- Bin mapping, with k = bin - first_bin:
  - bin < first_bin or k >= n_active: index 0.
  - k % step_pilot == step_pilot-1: index 2, and opilot_idx = k/step_pilot.
  - otherwise: index 1.
- The pilot counter restarts on every accepted isop.
- End of symbol, when bin == fft_size-1 is accepted:
  - osym_cnt increments and wraps modulo 2^sym_w.
  - If the next ival carries isop and en=1, RUN restarts at bin 0 back-to-back with no bubble.
  - If that ival has no isop, the FSM enters OVERRUN and err_long pulses on that cycle.
  - If en=0, the FSM returns to IDLE.
- isop during RUN with bin != 0:
  - err_short pulses.
  - The current symbol is abandoned and osym_cnt is not incremented.
  - The isop bin starts a new symbol at bin 0, if en=1.
- OVERRUN: samples are dropped (oval=0). err_long pulses only once per overrun episode. The next ival&isop acts as in IDLE.
- en falling mid-symbol: the current symbol completes, then the FSM goes to IDLE.
- busy = 1 in RUN, and 0 in IDLE and OVERRUN.
- When oval=0, oindex and opilot_idx are driven 0.

## Timing
- Every output is registered. Latency is exactly 1 clk from an input bin to the output bin, with osub_i, osub_q, oindex, osop and opilot_idx aligned on that same cycle.
- err_short and err_long are registered alongside the offending bin's output cycle.
- osym_cnt updates on the cycle after the last bin is output.
- Asynchronous reset (rst=0):
  - The FSM goes to IDLE immediately.
  - All outputs go to 0 immediately, including osub_i/q, osym_cnt and the error pulses.
  - A symbol in progress is discarded.
  - After reset release, the first ival&isop with en=1 is accepted normally.
- There is no backpressure; the block must accept one bin per clk indefinitely.

## Structure
- Shared package eq_pkg holds:
  - the index enum (IDX_NULL = 0, IDX_DATA = 1, IDX_PILOT = 2, IDX_RSVD = 3);
  - the FSM state enum;
  - a function n_pilot(n_active, step_pilot).
- Sub-module eq_bin_map is combinational. It maps bin to {index, pilot strobe} and carries a step_pilot modulo counter. It is instantiated once.
- The top level contains the FSM, bin, symbol and pilot counters, and the output register stage.

## Test plan
- Clean symbol: isop plus 256 contiguous ival with defaults. Expected response:
  - bins 0–27 and 228–255 give index 0;
  - bins 31, 35, …, 227 give index 2;
  - 150 data bins and 50 pilots in total;
  - opilot_idx runs 0..49;
  - osym_cnt goes 0→1;
  - all outputs are delayed by 1 clk.
- Gapped input: same symbol with 30% random ival deassertion. Expected: identical index and opilot_idx sequence on oval cycles, and oval=0 in the gaps.
- Short symbol: isop reasserted at bin 100. Expected: err_short is a single pulse, osym_cnt is unchanged, and the new symbol starts at bin 0 with opilot_idx restarted.
- Long symbol: 260 ival after isop. Expected: err_long pulses once on the 257th sample, the extra 4 samples give oval=0, osym_cnt=1, and the next isop resumes normally.
- en dropped at bin 50. Expected: the symbol completes through bin 255, busy falls after that bin, and a following isop is ignored until en=1.
- Async reset at bin 120. Expected: all outputs are 0 without waiting for a clock edge, and a subsequent isop produces a clean symbol with osym_cnt 0→1.
